// File: rtl/mode_sw_debounce_pkg.sv
// Shared definitions for the mode switch debouncer: state encodings and defaults.
package mode_sw_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } sw_state_e;

  // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_CNT_W           = 24;

endpackage

// File: rtl/mode_sw_debounce_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset; reused for other switch pins.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_sync1;
  logic r_sync2;

  // Two stages give the first flop a full cycle to resolve metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
    end
  end

  assign q = r_sync2;

endmodule

// File: rtl/mode_sw_debounce.sv
// Mode switch conditioner: synchronise, debounce with a consecutive-sample counter,
// and produce a clean level, press/release strobes and a press-toggled mode bit.
//
// state       | meaning
// ------------+-----------------------------------------------
// S_LOW       | level accepted as released (0)
// S_WAIT_HIGH | candidate press, counting consecutive 1 samples
// S_HIGH      | level accepted as pressed (1)
// S_WAIT_LOW  | candidate release, counting consecutive 0 samples
module mode_sw_debounce
  import mode_sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic mode_toggle,
  output logic busy
);

  // DEBOUNCE_CYCLES must be >= 2: entering a WAIT state already counts one sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_sw_in;
  logic             w_sw_sync;

  sw_state_e        r_state;
  sw_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_release;
  logic             w_release_nxt;
  logic             r_toggle;
  logic             w_toggle_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  // Normalise polarity so everything downstream treats 1 as pressed.
  assign w_sw_in = sw_raw ^ ACTIVE_LOW;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (w_sw_in),
    .q     (w_sw_sync)
  );

  // Next-state, counter and output decode; any disagreement in WAIT drops the partial count.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_toggle_nxt  = r_toggle;

    case (r_state)
      S_LOW: begin
        if (w_sw_sync) begin
          w_state_nxt = S_WAIT_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!w_sw_sync) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_HIGH;
          w_cnt_nxt    = '0;
          w_level_nxt  = 1'b1;
          w_press_nxt  = 1'b1;
          w_toggle_nxt = ~r_toggle;
        end else begin
          w_cnt_nxt    = r_cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!w_sw_sync) begin
          w_state_nxt = S_WAIT_LOW;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (w_sw_sync) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = S_LOW;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_WAIT_HIGH) || (w_state_nxt == S_WAIT_LOW);
  end

  // State, counter and registered outputs; busy is registered from the next state so it tracks r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_toggle  <= w_toggle_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign sw_level      = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign mode_toggle   = r_toggle;
  assign busy          = r_busy;

endmodule

// File: tb/tb_mode_sw_debounce.sv
// Scoreboard bench: dut0 is active-high, dut1 is active-low and sees the inverted pin,
// so both must produce identical events for the same physical presses.
module tb_mode_sw_debounce;

  localparam int D = 4;

  typedef struct {
    bit is_press;
    int at_cyc;
    bit tog;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_raw;
  logic       sw_raw_n;
  logic [1:0] lvl, prs, rel, tog, bsy;

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int overlaps = 0;
  int n_press  = 0;
  int press_seen [2];
  ev_t q0 [$];
  ev_t q1 [$];

  assign sw_raw_n = ~sw_raw;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mode_sw_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut0 (
    .clk           (clk),
    .reset         (reset),
    .sw_raw        (sw_raw),
    .sw_level      (lvl[0]),
    .press_pulse   (prs[0]),
    .release_pulse (rel[0]),
    .mode_toggle   (tog[0]),
    .busy          (bsy[0])
  );

  mode_sw_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(24), .ACTIVE_LOW(1'b1)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .sw_raw        (sw_raw_n),
    .sw_level      (lvl[1]),
    .press_pulse   (prs[1]),
    .release_pulse (rel[1]),
    .mode_toggle   (tog[1]),
    .busy          (bsy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A pin change driven now is sampled at edge cyc+1 and commits D+1 edges later.
  task automatic expect_ev(input bit is_press, input bit t);
    ev_t e;
    e.is_press = is_press;
    e.at_cyc   = cyc + D + 2;
    e.tog      = t;
    q0.push_back(e);
    q1.push_back(e);
    if (is_press) n_press++;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prs[i] && rel[i]) overlaps++;
      if (prs[i] || rel[i]) begin
        ev_t e;
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse dut%0d: press=%0d release=%0d at cycle %0d, expected none",
                   i, prs[i], rel[i], cyc);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("pulse_kind_dut%0d", i), 32'(prs[i]), 32'(e.is_press));
          chk($sformatf("pulse_cycle_dut%0d", i), cyc, e.at_cyc);
          chk($sformatf("pulse_level_dut%0d", i), 32'(lvl[i]), 32'(e.is_press));
          chk($sformatf("pulse_toggle_dut%0d", i), 32'(tog[i]), 32'(e.tog));
        end
        if (prs[i]) press_seen[i]++;
      end
    end
  end

  initial begin
    bit pat [6];
    bit etog;
    pat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    etog = 1'b0;
    press_seen[0] = 0;
    press_seen[1] = 0;

    // Reset state
    reset  = 1'b1;
    sw_raw = 1'b0;
    step(3);
    chk("rst_level", 32'(lvl), 0);
    chk("rst_pulses", 32'({prs, rel}), 0);
    chk("rst_toggle", 32'(tog), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_cnt", 32'(dut0.r_cnt), 0);
    reset = 1'b0;
    step(2);

    // Clean press: busy over cycles 2-4 after edge 0, level/pulse at edge 5
    sw_raw = 1'b1;
    etog   = ~etog;
    expect_ev(1'b1, etog);
    step(2);  chk("t1_busy_pre", 32'(bsy), 0);
    step(1);  chk("t1_busy_first", 32'(bsy), 3);
    step(2);  chk("t1_busy_last", 32'(bsy), 3);
    step(1);  chk("t1_busy_done", 32'(bsy), 0);
              chk("t1_level", 32'(lvl), 3);
              chk("t1_press_now", 32'(prs), 3);
    step(1);  chk("t1_press_gone", 32'(prs), 0);
              chk("t1_toggle", 32'(tog), 3);

    // Release
    sw_raw = 1'b0;
    expect_ev(1'b0, etog);
    step(D + 4);
    chk("t1r_level", 32'(lvl), 0);

    // Bounce rejection: never reaches the terminal count
    for (int i = 0; i < 6; i++) begin
      sw_raw = pat[i];
      step(1);
    end
    sw_raw = 1'b0;
    step(1);  chk("t2_busy_mid", 32'(bsy), 3);
    step(1);  chk("t2_busy_end", 32'(bsy), 0);
    step(4);  chk("t2_level", 32'(lvl), 0);
              chk("t2_cnt", 32'(dut0.r_cnt), 0);
              chk("t2_toggle", 32'(tog), 3);

    // Reset mid-qualification with the switch held
    sw_raw = 1'b1;
    step(4);  chk("t5_busy_pre", 32'(bsy), 3);
              chk("t5_cnt_pre", 32'(dut0.r_cnt), 2);
    reset = 1'b1;
    step(1);  chk("t5_rst_level", 32'(lvl), 0);
              chk("t5_rst_pulses", 32'({prs, rel}), 0);
              chk("t5_rst_toggle", 32'(tog), 0);
              chk("t5_rst_busy", 32'(bsy), 0);
              chk("t5_rst_cnt", 32'(dut1.r_cnt), 0);
    reset = 1'b0;
    etog  = 1'b1;
    expect_ev(1'b1, etog);
    step(D + 1);  chk("t5_level_early", 32'(lvl), 0);
    step(1);      chk("t5_level_late", 32'(lvl), 3);
    sw_raw = 1'b0;
    expect_ev(1'b0, etog);
    step(D + 4);

    // Glitch then settle: one press counted from the final rising drive
    sw_raw = 1'b1; step(1);
    sw_raw = 1'b0; step(1);
    sw_raw = 1'b1;
    etog = ~etog;
    expect_ev(1'b1, etog);
    step(D + 1);  chk("t3_level_early", 32'(lvl), 0);
    step(3);      chk("t3_level", 32'(lvl), 3);
    sw_raw = 1'b0;
    expect_ev(1'b0, etog);
    step(D + 4);

    // Two more press/release pairs: toggle goes 0 -> 1 -> 0
    for (int k = 0; k < 2; k++) begin
      sw_raw = 1'b1;
      etog = ~etog;
      expect_ev(1'b1, etog);
      step(D + 4);
      sw_raw = 1'b0;
      expect_ev(1'b0, etog);
      step(D + 4);
    end
    chk("t6_toggle", 32'(tog), 0);
    chk("t6_level", 32'(lvl), 0);

    step(2);
    chk("pending_dut0", q0.size(), 0);
    chk("pending_dut1", q1.size(), 0);
    chk("press_count_dut0", press_seen[0], n_press);
    chk("press_count_dut1", press_seen[1], n_press);
    chk("press_release_overlap", overlaps, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
